// File: rtl/fpu_misc_wb_pkg.sv
// fpu_misc_wb_pkg: shared FPU flag positions, canonical recoded NaNs, NaN-box
// constant and the result-buffer entry type.
package fpu_misc_wb_pkg;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;
    localparam logic [32:0] REC32_NAN = 33'h0_E040_0000;
    localparam logic [64:0] REC64_NAN = 65'h0_E008_0000_0000_0000;
    localparam logic [31:0] NAN_BOX   = 32'hFFFF_FFFF;
    typedef logic [4:0] flags_t;
    typedef struct packed {
        logic [64:0] rec;
        flags_t      exc;
        logic        fp64;
    } entry_t;
endpackage

// File: rtl/fpu_misc_wb_if.sv
// fpu_misc_wb_if: FP misc result channel in, regfile writeback channel out.
interface fpu_misc_wb_if #(parameter int TAG_W = 5);
    logic             in_valid;
    logic             in_ready;
    logic [64:0]      in_rec_data;
    logic [4:0]       in_exc;
    logic             in_fp64;
    logic [TAG_W-1:0] in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [4:0]       out_exc;
    logic [TAG_W-1:0] out_rd;
    modport master (
        output in_valid, in_rec_data, in_exc, in_fp64, in_rd, out_ready,
        input  in_ready, out_valid, out_data, out_exc, out_rd
    );
    modport slave (
        input  in_valid, in_rec_data, in_exc, in_fp64, in_rd, out_ready,
        output in_ready, out_valid, out_data, out_exc, out_rd
    );
endinterface

// File: rtl/fpu_misc_wb_rec_to_ieee.sv
// fpu_misc_wb_rec_to_ieee: combinational recoded-float to IEEE-754 conversion.
module fpu_misc_wb_rec_to_ieee #(
    parameter int EXP = 8,
    parameter int SIG = 24
) (
    input  logic [EXP+SIG:0]   rec,
    output logic [EXP+SIG-1:0] ieee
);
    localparam logic [EXP:0] BIAS     = (EXP+1)'((1 << (EXP - 1)) + 1);
    localparam logic [EXP:0] MIN_NORM = (EXP+1)'((1 << (EXP - 1)) + 2);
    logic [EXP:0]   exp_in, shift;
    logic [SIG-2:0] fract, den, fract_out;
    logic [EXP-1:0] exp_out;
    logic           special, is_nan, is_inf, is_zero, is_sub;
    assign exp_in  = rec[EXP+SIG-1:SIG-1];
    assign fract   = rec[SIG-2:0];
    assign special = &exp_in[EXP:EXP-1];
    assign is_nan  = special & exp_in[EXP-2];
    assign is_inf  = special & ~exp_in[EXP-2];
    assign is_zero = exp_in[EXP:EXP-2] == 3'b000;
    assign is_sub  = exp_in < MIN_NORM;
    // Subnormals: re-insert the hidden bit and shift it back below the binary point.
    assign shift     = BIAS - exp_in;
    assign den       = (SIG-1)'(({~is_zero, fract} >> shift) >> 1);
    assign exp_out   = is_sub ? '0 : (is_nan | is_inf) ? '1 : EXP'(exp_in - BIAS);
    assign fract_out = is_sub ? den : is_inf ? '0 : fract;
    assign ieee      = {rec[EXP+SIG], exp_out, fract_out};
endmodule

// File: rtl/fpu_misc_wb.sv
// fpu_misc_wb: circular result buffer for FP misc ops; the head entry is
// converted from recoded to IEEE form and its flags accrue on writeback.
module fpu_misc_wb
    import fpu_misc_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   flush,
    input  logic                   fflags_clr,
    fpu_misc_wb_if.slave           bus,
    output flags_t                 fflags_acc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    entry_t           mem    [DEPTH];
    logic [TAG_W-1:0] rd_mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             empty, full, push, pop;
    entry_t           head;
    logic [31:0]      ieee32;
    logic [63:0]      ieee64;
    assign empty         = wptr == rptr;
    assign full          = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count         = wptr - rptr;
    assign bus.in_ready  = ~full & ~flush;
    assign bus.out_valid = ~empty;
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    assign head          = mem[rptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]]    <= '{rec: bus.in_rec_data, exc: bus.in_exc, fp64: bus.in_fp64};
            rd_mem[wptr[AW-1:0]] <= bus.in_rd;
        end
    end
    // A pop in the flush cycle still accrues its flags; flush leaves fflags_acc alone.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wptr       <= '0;
            rptr       <= '0;
            fflags_acc <= '0;
        end else begin
            wptr       <= flush ? '0 : wptr + (AW+1)'(push);
            rptr       <= flush ? '0 : rptr + (AW+1)'(pop);
            fflags_acc <= (fflags_clr ? '0 : fflags_acc) | (pop ? bus.out_exc : '0);
        end
    end
    fpu_misc_wb_rec_to_ieee #(.EXP(8), .SIG(24)) u_cvt32 (.rec(head.rec[32:0]), .ieee(ieee32));
    fpu_misc_wb_rec_to_ieee #(.EXP(11), .SIG(53)) u_cvt64 (.rec(head.rec), .ieee(ieee64));
    assign bus.out_data = empty ? '0 : head.fp64 ? ieee64 : {NAN_BOX, ieee32};
    assign bus.out_exc  = empty ? '0 : head.exc;
    assign bus.out_rd   = empty ? '0 : rd_mem[rptr[AW-1:0]];
endmodule
